fsm_cfg_master: RTL and testbench
=================================

// Module: fsm_cfg_master
// PURPOSE
//  Host-side counterpart of the FIFO-status fsm: drives its init pulse and six almost-full/empty
//  threshold buses, then consumes its error/active/idle outputs. Validates and loads thresholds,
//  sequences init, confirms the fsm left INIT, then monitors it. Captures a sticky error code and
//  keeps a saturating error count for the host.
// PARAMETERS
//  INIT_CYCLES  4    cycles init held high per configuration (>=1)
//  TIMEOUT      255  max cycles in S_WAIT for idle/active before fault (8-bit counter)
// PORTS
//  clk             in   1  single clock, all logic on posedge
//  reset           in   1  synchronous, active-high reset
//  start           in   1  request (re)configuration; sampled in S_IDLE and S_RUN
//  clear           in   1  leave S_FAULT; sampled in S_FAULT only
//  cfg_afMF/aeMF   in   3  requested MF almost-full / almost-empty thresholds
//  cfg_afVC/aeVC   in   4  requested VC thresholds
//  cfg_afD/aeD     in   3  requested D thresholds
//  error_out_cond  in   5  error vector from fsm (non-zero = error)
//  active_out_cond in   1  fsm in ACTIVE
//  idle_out_cond   in   1  fsm in IDLE
//  init            out  1  init to fsm
//  afMFs/aeMFs     out  3  registered MF thresholds to fsm
//  afVCs/aeVCs     out  4  registered VC thresholds
//  afDs/aeDs       out  3  registered D thresholds
//  busy            out  1  high in S_LOAD, S_INIT, S_WAIT
//  cfg_done        out  1  1-cycle pulse on entry to S_RUN
//  cfg_err         out  1  1-cycle pulse: start rejected (bad thresholds)
//  error_flag      out  1  high while in S_FAULT
//  error_code      out  5  captured error vector; 5'b11111 = wait timeout
//  error_count     out  8  faults since reset, saturates at 255
// BEHAVIOUR
//  - Reset: state S_IDLE; every output 0; threshold regs 0; counters 0. Reset mid-operation aborts
//    immediately (init drops next edge).
//  - All outputs registered. States S_IDLE, S_LOAD, S_INIT, S_WAIT, S_RUN, S_FAULT.
//  - S_IDLE: on start, validate ae<af for all three pairs (unsigned). All valid -> S_LOAD.
//    Any ae>=af -> cfg_err pulse, stay S_IDLE, threshold outputs unchanged.
//  - S_LOAD (1 cycle): cfg_* copied to threshold outputs -> S_INIT. Outputs then stable until
//    next accepted start.
//  - S_INIT: init=1 exactly INIT_CYCLES cycles; first init-high cycle is 2 cycles after the cycle
//    start was sampled. Then -> S_WAIT, init=0.
//  - S_WAIT: wait counter from 0. idle_out_cond|active_out_cond -> S_RUN, cfg_done pulse.
//    Both high same cycle accepted the same. error_out_cond!=0 -> S_FAULT (error wins).
//  - S_RUN: error_out_cond!=0 -> S_FAULT, capture vector into error_code.
//    Else start -> same validation as S_IDLE: valid -> S_LOAD, invalid -> cfg_err, stay S_RUN.
//    Error and start same cycle: error wins, start dropped.
//  - S_FAULT: error_flag=1; error_code held; error_count +1 on entry, saturating.
//    clear -> S_IDLE, error_flag=0, error_code kept until next fault. start ignored;
//    start+clear same cycle: clear only.
//  - init never high outside S_INIT. busy and error_flag never both high.
// CONFIGURATION
//  FSMCFG_TIMEOUT_EN defined: in S_WAIT, counter reaching TIMEOUT with no idle/active/error ->
//   S_FAULT, error_code=5'b11111, error_count increments.
//  Not defined: no counter, S_WAIT waits indefinitely; error_code never 5'b11111.
// TESTING
//  1 reset 3 cycles -> all outputs 0, state S_IDLE; start cfg_afMF=6,aeMF=1,afVC=12,aeVC=2,
//    afD=5,aeD=1 -> thresholds match; init high 4 cycles from start+2; busy until idle=1;
//    cfg_done 1 pulse.
//  2 start with cfg_aeVC=12, cfg_afVC=12 -> cfg_err 1 pulse, init stays 0, outputs unchanged.
//  3 in S_RUN drive error_out_cond=5'b00100 one cycle -> error_flag=1, error_code=4,
//    error_count=1; clear -> error_flag=0, code still 4.
//  4 FSMCFG_TIMEOUT_EN, hold idle/active=0 after init -> fault after 255 S_WAIT cycles,
//    error_code=31; without macro, still busy after 1000 cycles.
//  5 in S_RUN, start and error_out_cond=1 same cycle -> S_FAULT, no S_LOAD; 256 faults ->
//    error_count=255.
//  6 reset high during S_INIT -> init=0, busy=0, thresholds 0 next edge.

Source files
------------

// File: rtl/fsm_cfg_master_if.sv
// rtl/fsm_cfg_master_if.sv - link between the configuration master and the FIFO-status fsm
//
// Master side drives:  init, afMFs/aeMFs (3b), afVCs/aeVCs (4b), afDs/aeDs (3b)
// Slave side drives:   error_out_cond (5b), active_out_cond, idle_out_cond
interface fsm_cfg_master_if;
  logic       init;
  logic [2:0] afMFs;
  logic [2:0] aeMFs;
  logic [3:0] afVCs;
  logic [3:0] aeVCs;
  logic [2:0] afDs;
  logic [2:0] aeDs;
  logic [4:0] error_out_cond;
  logic       active_out_cond;
  logic       idle_out_cond;

  modport master (
    output init, afMFs, aeMFs, afVCs, aeVCs, afDs, aeDs,
    input  error_out_cond, active_out_cond, idle_out_cond
  );

  modport slave (
    input  init, afMFs, aeMFs, afVCs, aeVCs, afDs, aeDs,
    output error_out_cond, active_out_cond, idle_out_cond
  );
endinterface

// File: rtl/fsm_cfg_master.sv
// rtl/fsm_cfg_master.sv - validates/loads fsm thresholds, sequences init, monitors fsm faults
//
// Optional feature macro: FSMCFG_TIMEOUT_EN (S_WAIT timeout -> fault with code 5'b11111)
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    request (re)configuration (S_IDLE / S_RUN)
//   clear                    leave S_FAULT
//   cfg_af*/cfg_ae*          requested thresholds (MF 3b, VC 4b, D 3b)
//   fsm                      master modport: init + thresholds out, error/active/idle in
//   busy                     high in S_LOAD, S_INIT, S_WAIT
//   cfg_done                 1-cycle pulse on entry to S_RUN
//   cfg_err                  1-cycle pulse when a start is rejected
//   error_flag               high while in S_FAULT
//   error_code               captured error vector (5'b11111 = wait timeout)
//   error_count              saturating fault count since reset
module fsm_cfg_master #(
  parameter int INIT_CYCLES = 4
`ifdef FSMCFG_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [2:0]            cfg_afMF,
  input  logic [2:0]            cfg_aeMF,
  input  logic [3:0]            cfg_afVC,
  input  logic [3:0]            cfg_aeVC,
  input  logic [2:0]            cfg_afD,
  input  logic [2:0]            cfg_aeD,
  fsm_cfg_master_if.master      fsm,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  error_flag,
  output logic [4:0]            error_code,
  output logic [7:0]            error_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_WAIT, S_RUN, S_FAULT} state_t;

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

  state_t     state;
  logic [7:0] init_cnt;
  logic       cfg_ok;
  logic       fsm_err;
  logic [7:0] count_next;

`ifdef FSMCFG_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  // Each almost-empty threshold must sit strictly below its almost-full partner.
  assign cfg_ok     = (cfg_aeMF < cfg_afMF) && (cfg_aeVC < cfg_afVC) && (cfg_aeD < cfg_afD);
  assign fsm_err    = |fsm.error_out_cond;
  assign count_next = (error_count == 8'hFF) ? error_count : error_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      init_cnt    <= 8'd0;
      fsm.init    <= 1'b0;
      fsm.afMFs   <= 3'd0;
      fsm.aeMFs   <= 3'd0;
      fsm.afVCs   <= 4'd0;
      fsm.aeVCs   <= 4'd0;
      fsm.afDs    <= 3'd0;
      fsm.aeDs    <= 3'd0;
      busy        <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      error_flag  <= 1'b0;
      error_code  <= 5'd0;
      error_count <= 8'd0;
`ifdef FSMCFG_TIMEOUT_EN
      wait_cnt    <= 8'd0;
`endif
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          fsm.afMFs <= cfg_afMF;
          fsm.aeMFs <= cfg_aeMF;
          fsm.afVCs <= cfg_afVC;
          fsm.aeVCs <= cfg_aeVC;
          fsm.afDs  <= cfg_afD;
          fsm.aeDs  <= cfg_aeD;
          fsm.init  <= 1'b1;
          init_cnt  <= 8'd0;
          state     <= S_INIT;
        end
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            fsm.init <= 1'b0;
            state    <= S_WAIT;
`ifdef FSMCFG_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
          end else begin
            init_cnt <= init_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          // An error reported alongside idle/active takes priority.
          if (fsm_err) begin
            state       <= S_FAULT;
            busy        <= 1'b0;
            error_flag  <= 1'b1;
            error_code  <= fsm.error_out_cond;
            error_count <= count_next;
          end else if (fsm.idle_out_cond || fsm.active_out_cond) begin
            state    <= S_RUN;
            busy     <= 1'b0;
            cfg_done <= 1'b1;
          end
`ifdef FSMCFG_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= S_FAULT;
            busy        <= 1'b0;
            error_flag  <= 1'b1;
            error_code  <= 5'b11111;
            error_count <= count_next;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        S_RUN: begin
          if (fsm_err) begin
            state       <= S_FAULT;
            error_flag  <= 1'b1;
            error_code  <= fsm.error_out_cond;
            error_count <= count_next;
          end else if (start) begin
            if (cfg_ok) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          // start is deliberately ignored here; only clear exits.
          if (clear) begin
            state      <= S_IDLE;
            error_flag <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          fsm.init <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_cfg_master.sv
// tb/tb_fsm_cfg_master.sv - randomized self-checking bench for fsm_cfg_master
module tb_fsm_cfg_master;
  localparam int INIT = 4;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, clear;
  logic [2:0] cfg_afMF, cfg_aeMF, cfg_afD, cfg_aeD;
  logic [3:0] cfg_afVC, cfg_aeVC;
  logic       busy, cfg_done, cfg_err, error_flag;
  logic [4:0] error_code;
  logic [7:0] error_count;

  fsm_cfg_master_if fsm_bus ();

  fsm_cfg_master dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .cfg_afMF(cfg_afMF), .cfg_aeMF(cfg_aeMF), .cfg_afVC(cfg_afVC), .cfg_aeVC(cfg_aeVC),
    .cfg_afD(cfg_afD), .cfg_aeD(cfg_aeD), .fsm(fsm_bus),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .error_flag(error_flag),
    .error_code(error_code), .error_count(error_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: expected threshold outputs, error record, abstract mode.
  logic [2:0] m_afMF, m_aeMF, m_afD, m_aeD;
  logic [3:0] m_afVC, m_aeVC;
  logic [4:0] m_code;
  int         m_count;
  int         mode;  // 0 idle, 1 running, 2 fault

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_thr();
    check("afMFs", fsm_bus.afMFs, m_afMF);
    check("aeMFs", fsm_bus.aeMFs, m_aeMF);
    check("afVCs", fsm_bus.afVCs, m_afVC);
    check("aeVCs", fsm_bus.aeVCs, m_aeVC);
    check("afDs",  fsm_bus.afDs,  m_afD);
    check("aeDs",  fsm_bus.aeDs,  m_aeD);
  endtask

  task automatic model_reset();
    m_afMF = 0; m_aeMF = 0; m_afVC = 0; m_aeVC = 0; m_afD = 0; m_aeD = 0;
    m_code = 0; m_count = 0; mode = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    fsm_bus.error_out_cond = 5'd0; fsm_bus.idle_out_cond = 1'b0; fsm_bus.active_out_cond = 1'b0;
    repeat (n) tick();
    model_reset();
    check_thr();
    check("rst_init", fsm_bus.init, 0);
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_flag", error_flag, 0);
    check("rst_code", error_code, 0);
    check("rst_count", error_count, 0);
    reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [2:0] afmf, aemf, input logic [3:0] afvc, aevc,
                         input logic [2:0] afd, aed);
    cfg_afMF = afmf; cfg_aeMF = aemf; cfg_afVC = afvc;
    cfg_aeVC = aevc; cfg_afD = afd; cfg_aeD = aed;
  endtask

  task automatic fault_checks(input logic [4:0] vec);
    m_code = vec;
    if (m_count < 255) m_count++;
    mode = 2;
    check("flt_flag", error_flag, 1);
    check("flt_code", error_code, m_code);
    check("flt_count", error_count, m_count);
    check("flt_busy", busy, 0);
    check("flt_init", fsm_bus.init, 0);
    check_thr();
  endtask

  // Start a configuration from idle/run; stays in S_WAIT for wt cycles, then either
  // releases with idle/active or reports wait_err.
  task automatic run_config(input logic [2:0] afmf, aemf, input logic [3:0] afvc, aevc,
                            input logic [2:0] afd, aed, input int wt, input logic [4:0] wait_err);
    bit ok;
    int r;
    ok = (aemf < afmf) && (aevc < afvc) && (aed < afd);
    set_cfg(afmf, aemf, afvc, aevc, afd, aed);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!ok) begin
      check("rej_pulse", cfg_err, 1);
      check("rej_busy", busy, 0);
      tick();
      check("rej_pulse_end", cfg_err, 0);
      check("rej_init", fsm_bus.init, 0);
      check_thr();
      return;
    end
    check("acc_err", cfg_err, 0);
    check("acc_busy", busy, 1);
    check("acc_init0", fsm_bus.init, 0);
    m_afMF = afmf; m_aeMF = aemf; m_afVC = afvc; m_aeVC = aevc; m_afD = afd; m_aeD = aed;
    for (int i = 1; i <= INIT + 1; i++) begin
      tick();
      check("init_seq", fsm_bus.init, (i <= INIT) ? 1 : 0);
      check("init_busy", busy, 1);
      if (i == 1) check_thr();
    end
    repeat (wt) tick();
    check("wait_busy", busy, 1);
    if (wait_err != 5'd0) begin
      fsm_bus.error_out_cond = wait_err;
      fsm_bus.idle_out_cond = 1'b1;
      tick();
      fsm_bus.error_out_cond = 5'd0;
      fsm_bus.idle_out_cond = 1'b0;
      fault_checks(wait_err);
      return;
    end
    r = $urandom_range(0, 2);
    fsm_bus.idle_out_cond   = (r != 1);
    fsm_bus.active_out_cond = (r != 0);
    tick();
    fsm_bus.idle_out_cond = 1'b0;
    fsm_bus.active_out_cond = 1'b0;
    check("done_pulse", cfg_done, 1);
    check("done_busy", busy, 0);
    tick();
    check("done_pulse_end", cfg_done, 0);
    mode = 1;
  endtask

  task automatic inject_error(input logic [4:0] vec, input bit with_start);
    fsm_bus.error_out_cond = vec;
    start = with_start;
    tick();
    fsm_bus.error_out_cond = 5'd0;
    start = 1'b0;
    fault_checks(vec);
    tick();
    check("flt_hold", error_flag, 1);
    check("flt_noload", busy, 0);
  endtask

  task automatic do_clear(input bit with_start);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flt_ign_start", busy, 0);
    check("flt_still", error_flag, 1);
    clear = 1'b1;
    start = with_start;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_flag", error_flag, 0);
    check("clr_code", error_code, m_code);
    check("clr_count", error_count, m_count);
    tick();
    check("clr_busy", busy, 0);
    mode = 0;
  endtask

  task automatic rand_cfg(output logic [2:0] afmf, aemf, output logic [3:0] afvc, aevc,
                          output logic [2:0] afd, aed);
    afmf = 3'($urandom_range(1, 7)); aemf = 3'($urandom_range(0, int'(afmf) - 1));
    afvc = 4'($urandom_range(1, 15)); aevc = 4'($urandom_range(0, int'(afvc) - 1));
    afd  = 3'($urandom_range(1, 7)); aed  = 3'($urandom_range(0, int'(afd) - 1));
    if ($urandom_range(0, 9) < 3) begin
      case ($urandom_range(0, 2))
        0:       aemf = 3'($urandom_range(int'(afmf), 7));
        1:       aevc = 4'($urandom_range(int'(afvc), 15));
        default: aed  = 3'($urandom_range(int'(afd), 7));
      endcase
    end
  endtask

  initial begin
    logic [2:0] a, b, e, f;
    logic [3:0] c, d;
    int n;

    set_cfg(0, 0, 0, 0, 0, 0);
    do_reset(3);

    run_config(6, 1, 12, 2, 5, 1, 3, 5'd0);
    run_config(6, 1, 12, 12, 5, 1, 0, 5'd0);
    inject_error(5'b00100, 1'b0);
    do_clear(1'b0);
    check("code_kept", error_code, 4);

    // Wait-state timeout behaviour.
    set_cfg(5, 2, 9, 3, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_afMF = 5; m_aeMF = 2; m_afVC = 9; m_aeVC = 3; m_afD = 4; m_aeD = 0;
    repeat (INIT + 1) tick();
`ifdef FSMCFG_TIMEOUT_EN
    n = 0;
    while (!error_flag && n < 400) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TMO);
    fault_checks(5'b11111);
    do_clear(1'b1);
`else
    n = TMO;
    repeat (1000) tick();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_flag", error_flag, 0);
    check("no_timeout_code", error_code, m_code);
    fsm_bus.active_out_cond = 1'b1;
    tick();
    fsm_bus.active_out_cond = 1'b0;
    check("late_done", cfg_done, 1);
    check_thr();
    mode = 1;
`endif

    if (mode != 1) run_config(6, 1, 12, 2, 5, 1, 0, 5'd0);
    inject_error(5'd1, 1'b1);
    do_clear(1'b1);
    run_config(7, 0, 15, 14, 3, 2, 2, 5'b10010);
    do_clear(1'b0);

    for (int it = 0; it < 40; it++) begin
      if (mode == 2) begin
        do_clear(1'($urandom_range(0, 1)));
      end else if (mode == 1 && $urandom_range(0, 3) == 0) begin
        inject_error(5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
      end else begin
        rand_cfg(a, b, c, d, e, f);
        run_config(a, b, c, d, e, f, $urandom_range(0, 15),
                   ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
      end
    end
    if (mode == 2) do_clear(1'b0);

    // Drive the fault counter into saturation.
    while (m_count < 256 && vectors < 200000) begin
      if (mode != 1) run_config(6, 1, 12, 2, 5, 1, 0, 5'd0);
      inject_error(5'($urandom_range(1, 31)), 1'b0);
      do_clear(1'b0);
      if (m_count == 255) break;
    end
    run_config(3, 1, 8, 7, 2, 1, 0, 5'd0);
    inject_error(5'b01010, 1'b1);
    check("count_sat", error_count, 255);
    do_clear(1'b0);

    // Reset in the middle of the init pulse.
    set_cfg(4, 3, 10, 1, 6, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_init_high", fsm_bus.init, 1);
    reset = 1'b1;
    tick();
    model_reset();
    check("abort_init", fsm_bus.init, 0);
    check("abort_busy", busy, 0);
    check("abort_count", error_count, 0);
    check_thr();
    reset = 1'b0;
    tick();
    check("abort_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
